// File: rtl/calc_rtan_seq.sv
// calc_rtan_seq: sequential r*tan(k*STEP_DEG) via one shift-add multiplier, valid/ready on both sides
module calc_rtan_seq #(
  parameter int R_WIDTH   = 9,
  parameter int OUT_WIDTH = 11,
  parameter int FRAC_BITS = 11,
  parameter int STEP_DEG  = 15,
  parameter int IDX_WIDTH = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [R_WIDTH-1:0]   i_r_in,
  input  logic [IDX_WIDTH-1:0] i_angle_idx,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [OUT_WIDTH-1:0] o_rtan_out,
  output logic                 o_ovf,
  output logic                 o_err
);
  localparam int CW = FRAC_BITS + 4;
  localparam int AW = R_WIDTH + CW + 1;
  localparam int MW = R_WIDTH + 1;
  localparam int NW = $clog2(CW);
  localparam int DW = IDX_WIDTH + 7;
  localparam logic [20:0] RND = (21'd1 << 15) >> FRAC_BITS;
  localparam logic [OUT_WIDTH-1:0] MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, MUL, FIN, HOLD} state_t;

  state_t r_state, w_next;
  logic r_sign, r_is90, r_bad, r_ovf, r_err;
  logic [MW-1:0] r_mag;
  logic [CW-1:0] r_c;
  logic [AW-1:0] r_acc;
  logic [NW-1:0] r_cnt;
  logic [OUT_WIDTH-1:0] r_out;

  logic [DW-1:0] w_deg, w_k;
  logic w_err, w_90, w_sat, w_ovf;
  logic [19:0] w_c5;
  logic [CW-1:0] w_c;
  logic [MW-1:0] w_rx, w_abs;
  logic [AW-1:0] w_q;
  logic [OUT_WIDTH-1:0] w_m, w_res;

  // tan(5k deg) * 2^16, rounded
  function automatic logic [19:0] c5(input logic [DW-1:0] k);
    case (k)
      0:  c5 = 20'd0;      1:  c5 = 20'd5734;   2:  c5 = 20'd11556;
      3:  c5 = 20'd17560;  4:  c5 = 20'd23853;  5:  c5 = 20'd30560;
      6:  c5 = 20'd37837;  7:  c5 = 20'd45889;  8:  c5 = 20'd54991;
      9:  c5 = 20'd65536;  10: c5 = 20'd78103;  11: c5 = 20'd93595;
      12: c5 = 20'd113512; 13: c5 = 20'd140542; 14: c5 = 20'd180059;
      15: c5 = 20'd244584; 16: c5 = 20'd371673; 17: c5 = 20'd749080;
      default: c5 = 20'd0;
    endcase
  endfunction

  always_comb begin
    w_deg = DW'(i_angle_idx) * DW'(STEP_DEG);
    w_k   = DW'(i_angle_idx) * DW'(STEP_DEG / 5);
    w_err = w_deg > DW'(90);
    w_90  = w_deg == DW'(90);
    w_c5  = (w_err || w_90) ? 20'd0 : c5(w_k);
    w_c   = CW'((21'(w_c5) + RND) >> (16 - FRAC_BITS));
    w_rx  = {i_r_in[R_WIDTH-1], i_r_in};
    w_abs = w_rx[MW-1] ? -w_rx : w_rx;
    w_q   = r_acc >> FRAC_BITS;
    w_sat = w_q > AW'(MAX);
    w_m   = w_sat ? MAX : w_q[OUT_WIDTH-1:0];
    w_res = r_bad ? '0 : r_is90 ? (r_mag == '0 ? '0 : r_sign ? -MAX : MAX) : r_sign ? -w_m : w_m;
    w_ovf = r_bad ? 1'b0 : r_is90 ? (r_mag != '0) : w_sat;
  end

  always_comb begin
    w_next = r_state == IDLE ? (i_in_valid ? MUL : IDLE) :
             r_state == MUL  ? (r_cnt == NW'(CW - 1) ? FIN : MUL) :
             r_state == FIN  ? HOLD :
             (i_out_ready ? IDLE : HOLD);
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sign <= 1'b0;
      r_is90 <= 1'b0;
      r_bad  <= 1'b0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
      r_mag  <= '0;
      r_c    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
    end else if (r_state == IDLE && i_in_valid) begin
      r_sign <= i_r_in[R_WIDTH-1];
      r_mag  <= w_abs;
      r_c    <= w_c;
      r_is90 <= w_90;
      r_bad  <= w_err;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
    end else if (r_state == MUL) begin
      r_acc <= r_acc + (r_c[r_cnt] ? AW'(r_mag) << r_cnt : '0);
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == FIN) begin
      r_out <= w_res;
      r_ovf <= w_ovf;
      r_err <= r_bad;
    end
  end

  assign o_in_ready  = r_state == IDLE;
  assign o_out_valid = r_state == HOLD;
  assign o_rtan_out  = r_out;
  assign o_ovf       = r_ovf;
  assign o_err       = r_err;
endmodule

// File: tb/tb_calc_rtan_seq.sv
// tb_calc_rtan_seq: directed and random checks of calc_rtan_seq at STEP_DEG=15 and STEP_DEG=5
module tb_calc_rtan_seq;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic iv, ir, ov, ordy, ovf, err;
  logic [8:0] rin;
  logic [2:0] idx;
  logic [10:0] y;
  logic iv5, ir5, ov5, ordy5, ovf5, err5;
  logic [8:0] rin5;
  logic [4:0] idx5;
  logic [10:0] y5;

  int checks = 0, failures = 0;
  int ey, eovf, eerr;
  int c5_tab [0:17] = '{0, 5734, 11556, 17560, 23853, 30560, 37837, 45889, 54991,
                        65536, 78103, 93595, 113512, 140542, 180059, 244584, 371673, 749080};

  calc_rtan_seq u_a (
    .i_clk(clk), .i_rst(rst), .i_in_valid(iv), .o_in_ready(ir), .i_r_in(rin),
    .i_angle_idx(idx), .o_out_valid(ov), .i_out_ready(ordy), .o_rtan_out(y),
    .o_ovf(ovf), .o_err(err)
  );

  calc_rtan_seq #(.STEP_DEG(5), .IDX_WIDTH(5)) u_b (
    .i_clk(clk), .i_rst(rst), .i_in_valid(iv5), .o_in_ready(ir5), .i_r_in(rin5),
    .i_angle_idx(idx5), .o_out_valid(ov5), .i_out_ready(ordy5), .o_rtan_out(y5),
    .o_ovf(ovf5), .o_err(err5)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // r*tan(deg) with the coefficient rounded to 11 fractional bits, magnitude truncated, saturated to +/-1023
  function automatic void model(input int step, input int r, input int i);
    int deg, a, c, m;
    deg = i * step;
    a = r < 0 ? -r : r;
    eerr = deg > 90;
    if (eerr) begin
      ey = 0; eovf = 0;
    end else if (deg == 90) begin
      ey = r == 0 ? 0 : (r < 0 ? -1023 : 1023);
      eovf = r != 0;
    end else begin
      c = (c5_tab[deg / 5] + 16) / 32;
      m = (a * c) / 2048;
      eovf = m > 1023;
      if (m > 1023) m = 1023;
      ey = r < 0 ? -m : m;
    end
  endfunction

  task automatic start(input bit b, input int r, input int i);
    chk(b ? "b_in_ready_idle" : "a_in_ready_idle", b ? ir5 : ir, 1);
    if (b) begin iv5 = 1'b1; rin5 = r[8:0]; idx5 = i[4:0]; end
    else begin iv = 1'b1; rin = r[8:0]; idx = i[2:0]; end
    model(b ? 5 : 15, r, i);
    @(posedge clk); #1;
    iv = 1'b0; iv5 = 1'b0;
    chk(b ? "b_in_ready_busy" : "a_in_ready_busy", b ? ir5 : ir, 0);
  endtask

  task automatic release_out(input bit b);
    if (b) ordy5 = 1'b1; else ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0; ordy5 = 1'b0;
    chk("in_ready_after_release", b ? ir5 : ir, 1);
    chk("out_valid_after_release", b ? ov5 : ov, 0);
  endtask

  task automatic finish_txn(input bit b, input bit rel);
    int n = 1;
    while (!(b ? ov5 : ov) && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency_edges", n, 17);
    chk("rtan_out", b ? $signed(y5) : $signed(y), ey);
    chk("ovf", b ? ovf5 : ovf, eovf);
    chk("err", b ? err5 : err, eerr);
    if (rel) release_out(b);
  endtask

  int da_r [8] = '{100, -100, -256, 200, 0, -256, 55, 255};
  int da_i [8] = '{1, 1, 5, 2, 6, 6, 7, 0};
  int da_y [8] = '{26, -26, -955, 115, 0, -1023, 0, 0};
  int da_o [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  int da_e [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
  int db_r [4] = '{100, 100, -100, 5};
  int db_i [4] = '{17, 9, 18, 19};
  int db_y [4] = '{1023, 100, -1023, 0};
  int db_o [4] = '{1, 0, 1, 0};
  int db_e [4] = '{0, 0, 0, 1};
  logic [10:0] held;

  initial begin
    iv = 0; ordy = 0; rin = 0; idx = 0;
    iv5 = 0; ordy5 = 0; rin5 = 0; idx5 = 0;
    #2;
    chk("reset_in_ready", ir, 1);
    chk("reset_out_valid", ov, 0);
    chk("reset_rtan", y, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_err", err, 0);
    chk("reset_b_out_valid", ov5, 0);
    #10 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      start(0, da_r[k], da_i[k]);
      ey = da_y[k]; eovf = da_o[k]; eerr = da_e[k];
      finish_txn(0, 1);
    end
    for (int k = 0; k < 4; k++) begin
      start(1, db_r[k], db_i[k]);
      ey = db_y[k]; eovf = db_o[k]; eerr = db_e[k];
      finish_txn(1, 1);
    end
    for (int k = 0; k < 20; k++) begin
      start(0, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 7)));
      finish_txn(0, 1);
    end
    for (int k = 0; k < 12; k++) begin
      start(1, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 31)));
      finish_txn(1, 1);
    end
    // backpressure: result held while a competing request waits
    start(0, 123, 3);
    finish_txn(0, 0);
    held = y;
    for (int k = 0; k < 10; k++) begin
      iv = 1'b1; rin = 9'($urandom_range(0, 511)); idx = 3'($urandom_range(0, 7));
      @(posedge clk); #1;
      chk("bp_rtan_stable", y, held);
      chk("bp_out_valid", ov, 1);
      chk("bp_in_ready", ir, 0);
    end
    iv = 1'b0;
    release_out(0);
    @(posedge clk); #1;
    chk("bp_no_accept", ir, 1);
    // asynchronous reset in the middle of a multiply
    start(0, -77, 4);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", ov, 0);
    chk("arst_in_ready", ir, 1);
    chk("arst_rtan", y, 0);
    chk("arst_b_in_ready", ir5, 1);
    #1 rst = 1'b0;
    start(0, -77, 4);
    finish_txn(0, 1);
    start(1, 77, 12);
    finish_txn(1, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
